// File: rtl/apb_pkg.sv
// Shared APB definitions: sequencer state encoding, bus phase constants and
// default widths used by the arbiter and the apb_master port.
package apb_pkg;

    localparam int unsigned APB_AW = 16;
    localparam int unsigned APB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic psel;
        logic penable;
    } apb_phase_t;

    localparam apb_phase_t PH_IDLE   = '{psel: 1'b0, penable: 1'b0};
    localparam apb_phase_t PH_SETUP  = '{psel: 1'b1, penable: 1'b0};
    localparam apb_phase_t PH_ACCESS = '{psel: 1'b1, penable: 1'b1};

    // Watchdog must be able to hold the value TIMEOUT itself.
    function automatic int unsigned wdog_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1,
// wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        // Offsets 1..N visit every index once, ending on last itself.
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IW'((32'(last) + off) % N);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter and APB sequencer sharing one master port among NREQ
// requesters, with a per-transfer PREADY watchdog.
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = APB_AW,
    parameter int unsigned DW      = APB_DW,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ-1:0]    i_write,
    input  logic [NREQ*DW-1:0] i_wdata,
    output logic [NREQ-1:0]    o_ack,
    output logic [DW-1:0]      o_rdata,
    output logic               o_err,
    output logic               o_timeout,
    output logic [AW-1:0]      o_paddr,
    output logic               o_psel,
    output logic               o_penable,
    output logic               o_pwrite,
    output logic [DW-1:0]      o_pwdata,
    input  logic               i_pready,
    input  logic               i_pslverr,
    input  logic [DW-1:0]      i_prdata
);

    localparam int unsigned   IW       = $clog2(NREQ);
    localparam int unsigned   CW       = wdog_width(TIMEOUT);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
    localparam logic [CW-1:0] WDOG_MAX = CW'(TIMEOUT);

    apb_state_e      state;
    apb_phase_t      phase;
    logic [IW-1:0]   last;
    logic [NREQ-1:0] grant_oh;
    logic [CW-1:0]   wdog;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    int unsigned     sel;

    // A requester being acked this cycle has not had a chance to drop i_req yet.
    assign eligible = i_req & ~o_ack;
    assign sel      = 32'(pick_idx);

    rr_pick #(.N(NREQ)) u_pick (
        .req   (eligible),
        .last  (last),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign o_psel    = phase.psel;
    assign o_penable = phase.penable;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            phase     <= PH_IDLE;
            last      <= LAST_RST;
            grant_oh  <= '0;
            wdog      <= '0;
            o_ack     <= '0;
            o_rdata   <= '0;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
            o_paddr   <= '0;
            o_pwrite  <= 1'b0;
            o_pwdata  <= '0;
        end else begin
            o_ack     <= '0;
            o_rdata   <= '0;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_oh <= pick_oh;
                        last     <= pick_idx;
                        o_paddr  <= i_addr[sel*AW +: AW];
                        o_pwrite <= i_write[pick_idx];
                        o_pwdata <= i_wdata[sel*DW +: DW];
                        phase    <= PH_SETUP;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    phase <= PH_ACCESS;
                    wdog  <= '0;
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (i_pready) begin
                        phase   <= PH_IDLE;
                        state   <= ST_IDLE;
                        o_ack   <= grant_oh;
                        o_err   <= i_pslverr;
                        o_rdata <= o_pwrite ? '0 : i_prdata;
                    end else if (wdog == WDOG_MAX) begin
                        phase     <= PH_IDLE;
                        state     <= ST_IDLE;
                        o_ack     <= grant_oh;
                        o_err     <= 1'b1;
                        o_timeout <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    phase <= PH_IDLE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Round-robin arbiter and sequencer that shares one APB master port among `NREQ` internal requesters. It sits between bus-using blocks and the `apb_master` port. It drives the SETUP/ACCESS phases itself, returns read data and error status to the granted requester, and aborts transfers whose slave never asserts PREADY.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8)
- `AW`, 16: APB address width
- `DW`, 32: APB data width
- `TIMEOUT`, 64: maximum ACCESS cycles before abort (≥2)

Ports:
- `i_clk`  in  1  the only clock; all logic on its rising edge
- `i_reset_n`  in  1  synchronous, active-low reset
- `i_req`  in  NREQ  per-requester transfer request; level, held until matching `o_ack`
- `i_addr`  in  NREQ*AW  flattened addresses; requester k at bits [k*AW +: AW]
- `i_write`  in  NREQ  1 = write, 0 = read
- `i_wdata`  in  NREQ*DW  flattened write data, same packing as `i_addr`
- `o_ack`  out  NREQ  one-hot, one-cycle completion pulse
- `o_rdata`  out  DW  read data, valid only while `o_ack` is nonzero
- `o_err`  out  1  slave error or timeout, valid with `o_ack`
- `o_timeout`  out  1  high with `o_ack` when the transfer was aborted by the watchdog
- `o_paddr`  out  AW  APB address
- `o_psel`  out  1  APB select
- `o_penable`  out  1  APB enable
- `o_pwrite`  out  1  APB direction
- `o_pwdata`  out  DW  APB write data
- `i_pready`  in  1  APB ready
- `i_pslverr`  in  1  APB slave error
- `i_prdata`  in  DW  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - If any eligible `i_req` bit is set, pick a winner by round-robin.
  - Latch the winner's addr, write and wdata into the APB output registers and set `o_psel`=1.
  - Go to SETUP.
  - A requester whose `o_ack` bit is high in the current cycle is not eligible. This masks a request line that has not yet been dropped.
- **SETUP:** `o_penable`←1, go to ACCESS. Exactly one cycle.
- **ACCESS:** hold all APB outputs stable.
  - On `i_pready`=1: deassert `o_psel`/`o_penable` and go to IDLE. Assert `o_ack[grant]`, set `o_rdata`←`i_prdata` on a read (0 on a write) and `o_err`←`i_pslverr`.
  - Watchdog: count ACCESS cycles. If the count reaches `TIMEOUT` without `i_pready`, complete the transfer as above with `o_err`=1, `o_timeout`=1, `o_rdata`=0.
- **Round-robin rule:**
  - The pointer `last` holds the index of the most recent grant.
  - Search starts at `last+1` and wraps modulo `NREQ`. The lowest index at or after that start wins.
  - `last` updates only on a grant.
  - After reset `last`=NREQ-1, so requester 0 has top priority.
- **Request handling:**
  - Requesters must not change addr/write/wdata while `i_req` is high.
  - Dropping `i_req` mid-transfer does not cancel the transfer; its `o_ack` is still pulsed.
  - The arbiter samples requester inputs only in IDLE.
- **Reset:**
  - Asserting `i_reset_n`=0 in any state forces the following at the next edge: state IDLE; `o_psel`, `o_penable`, `o_pwrite`, `o_ack`, `o_err`, `o_timeout` = 0; `o_paddr`, `o_pwdata`, `o_rdata` = 0; watchdog counter 0; `last`=NREQ-1.
  - A transfer in flight when reset is asserted is dropped without an ack.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Uncontended read with zero wait states:
  - Cycle 0: `i_req` seen in IDLE.
  - Cycle 1: SETUP (`o_psel`=1).
  - Cycle 2: ACCESS (`o_penable`=1), `i_pready` sampled high.
  - Cycle 3: `o_ack` pulse with `o_rdata`.
- Latency is 3 + W cycles, where W is the number of wait states.
- Back-to-back transfers: the ack cycle is an IDLE cycle in which the next grant is taken. The next SETUP starts one cycle after the ack, giving one APB idle cycle between transfers.
- Watchdog abort: `o_ack` occurs `TIMEOUT` cycles after ACCESS entry, plus one.
- Watchdog counter width is `$clog2(TIMEOUT+1)`. It clears on entry to ACCESS and never wraps.

## Structure
- Shared package `apb_pkg`:
  - FSM state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2)
  - APB phase constants
  - default widths `APB_AW`/`APB_DW`, reused by `apb_master`
- Sub-module `rr_pick`:
  - purely combinational
  - inputs: eligible request vector, `last` pointer
  - outputs: one-hot grant, binary index, `any`
- The top module holds the FSM, pointer, watchdog, latches and output registers.

## Test plan
- Single read, zero waits: `i_req`=4'b0001, addr 0x0010, `i_prdata`=0xDEADBEEF → psel at cycle 1, penable at cycle 2, `o_ack`=0001, `o_rdata`=0xDEADBEEF, `o_err`=0 at cycle 3.
- Write with 2 wait states and PSLVERR: req 2, write 0x12345678 to 0x0040, pready at the 3rd ACCESS cycle with pslverr=1 → `o_pwdata` stable throughout, `o_ack`=0100, `o_err`=1, latency 5.
- Fairness: all four requests held continuously → grant order 0,1,2,3,0, with one idle cycle between psel periods.
- Timeout: `TIMEOUT`=4, `i_pready` tied low → `o_ack` 4 cycles after ACCESS entry plus one, with `o_err`=1, `o_timeout`=1, `o_rdata`=0.
- Stale request masking: requester 1 holds `i_req` through its ack cycle and requester 3 is also requesting → next grant is 3; requester 1 is served afterwards only if it is still requesting.
- Reset mid-ACCESS: `i_reset_n`=0 during wait states → next cycle all outputs 0 and no ack; after release, requester 0 wins first.
